// File: rtl/variable_pkg.sv
// Shared game-wide constants and types: player identities and the launch-speed FSM states.
package variable_pkg;

  localparam logic PLAYER_1 = 1'b0;
  localparam logic PLAYER_2 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FLY  = 2'd2
  } shot_speed_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/shot_speed_gen_wind_offset.sv
// Decodes the wind code into a signed, never-zero speed offset and orients it by shooter.
module wind_offset
  import variable_pkg::*;
#(
  parameter int WIND_W = 3
) (
  input  logic                     turn_i,
  input  logic [WIND_W-1:0]        wind_i,
  output logic signed [WIND_W:0]   delta_o
);

  localparam logic signed [WIND_W:0] ONE  = (WIND_W + 1)'(1);
  localparam logic signed [WIND_W:0] H_M1 = (WIND_W + 1)'(2 ** (WIND_W - 1) - 1);

  logic signed [WIND_W:0] w_ext;
  logic signed [WIND_W:0] base;

  // MSB clear means w < H: headwind side, magnitude w+1; otherwise w-(H-1).
  always_comb begin
    w_ext = {1'b0, wind_i};
    base  = '0;
    if (!wind_i[WIND_W-1]) begin
      base = -(w_ext + ONE);
    end else begin
      base = w_ext - H_M1;
    end
    delta_o = (turn_i == PLAYER_2) ? -base : base;
  end

endmodule

// File: rtl/shot_speed_gen.sv
// Launch-speed generator: latches shot operands, computes a clamped speed once per shot,
// and optionally decays it by one unit every DRAG_DIV frames while the projectile flies.
module shot_speed_gen
  import variable_pkg::*;
#(
  parameter int PW_W      = 4,
  parameter int WIND_W    = 3,
  parameter int SPD_W     = 5,
  parameter int MIN_SPEED = 0,
  parameter int DRAG_DIV  = 0
) (
  input  logic              clk60MHz,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic              shot_start,
  input  logic              shot_done,
  input  logic              turn,
  input  logic              current_player,
  input  logic [PW_W-1:0]   power,
  input  logic [PW_W-1:0]   in_power,
  input  logic [WIND_W-1:0] wind,
  output logic [SPD_W-1:0]  speed,
  output logic              speed_valid,
  output logic              busy
);

  localparam int AW        = max_int(PW_W, WIND_W) + 2;
  localparam int CW        = max_int(AW, SPD_W + 1);
  localparam int DW        = max_int(1, $clog2(DRAG_DIV + 1));
  localparam int DRAG_LAST = (DRAG_DIV > 0) ? DRAG_DIV - 1 : 0;

  localparam logic signed [CW-1:0] MIN_C     = CW'(MIN_SPEED);
  localparam logic signed [CW-1:0] MAX_C     = CW'(2 ** SPD_W - 1);
  localparam logic [SPD_W-1:0]     MIN_SPD   = SPD_W'(MIN_SPEED);
  localparam logic [SPD_W-1:0]     MAX_SPD   = SPD_W'(2 ** SPD_W - 1);
  localparam logic [SPD_W-1:0]     SPD_ONE   = SPD_W'(1);
  localparam logic [DW-1:0]        DRAG_END  = DW'(DRAG_LAST);
  localparam logic [DW-1:0]        DRAG_ONE  = DW'(1);

  shot_speed_state_t state_q;
  logic              turn_q;
  logic [WIND_W-1:0] wind_q;
  logic [PW_W-1:0]   pw_q;
  logic [SPD_W-1:0]  speed_q;
  logic              speed_valid_q;
  logic              busy_q;
  logic [DW-1:0]     drag_cnt_q;

  logic signed [WIND_W:0] delta;
  logic signed [CW-1:0]   sum;
  logic [SPD_W-1:0]       speed_d;

  wind_offset #(.WIND_W(WIND_W)) u_wind_offset (
    .turn_i  (turn_q),
    .wind_i  (wind_q),
    .delta_o (delta)
  );

  // Sum is wide enough that neither the addition nor the clamp compare can wrap.
  always_comb begin
    sum     = signed'(CW'(pw_q)) + CW'(delta);
    speed_d = sum[SPD_W-1:0];
    if (sum < MIN_C) begin
      speed_d = MIN_SPD;
    end else if (sum > MAX_C) begin
      speed_d = MAX_SPD;
    end
  end

  always_ff @(posedge clk60MHz or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      turn_q        <= PLAYER_1;
      wind_q        <= '0;
      pw_q          <= '0;
      speed_q       <= '0;
      speed_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      drag_cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (shot_start) begin
            state_q <= CALC;
            busy_q  <= 1'b1;
            turn_q  <= turn;
            wind_q  <= wind;
            pw_q    <= (current_player == turn) ? power : in_power;
          end
        end
        CALC: begin
          if (shot_done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q       <= FLY;
            speed_q       <= speed_d;
            speed_valid_q <= 1'b1;
            drag_cnt_q    <= '0;
          end
        end
        FLY: begin
          if (shot_done) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            speed_valid_q <= 1'b0;
          end else if (DRAG_DIV > 0 && frame_tick) begin
            if (drag_cnt_q == DRAG_END) begin
              drag_cnt_q <= '0;
              if (speed_q > MIN_SPD) begin
                speed_q <= speed_q - SPD_ONE;
              end
            end else begin
              drag_cnt_q <= drag_cnt_q + DRAG_ONE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign speed       = speed_q;
  assign speed_valid = speed_valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_shot_speed_gen.sv
// Directed bench for shot_speed_gen: default, raised-floor and drag-enabled instances share stimulus.
module tb_shot_speed_gen;

  logic       clk60MHz;
  logic       rst;
  logic       frame_tick;
  logic       shot_start;
  logic       shot_done;
  logic       turn;
  logic       current_player;
  logic [3:0] power;
  logic [3:0] in_power;
  logic [2:0] wind;

  logic [4:0] def_speed, min_speed, drg_speed;
  logic       def_valid, min_valid, drg_valid;
  logic       def_busy, min_busy, drg_busy;

  int n_cmp = 0;
  int n_bad = 0;

  shot_speed_gen u_def (
    .clk60MHz(clk60MHz), .rst(rst), .frame_tick(frame_tick), .shot_start(shot_start),
    .shot_done(shot_done), .turn(turn), .current_player(current_player), .power(power),
    .in_power(in_power), .wind(wind), .speed(def_speed), .speed_valid(def_valid), .busy(def_busy)
  );

  shot_speed_gen #(.MIN_SPEED(3)) u_min (
    .clk60MHz(clk60MHz), .rst(rst), .frame_tick(frame_tick), .shot_start(shot_start),
    .shot_done(shot_done), .turn(turn), .current_player(current_player), .power(power),
    .in_power(in_power), .wind(wind), .speed(min_speed), .speed_valid(min_valid), .busy(min_busy)
  );

  shot_speed_gen #(.DRAG_DIV(2)) u_drag (
    .clk60MHz(clk60MHz), .rst(rst), .frame_tick(frame_tick), .shot_start(shot_start),
    .shot_done(shot_done), .turn(turn), .current_player(current_player), .power(power),
    .in_power(in_power), .wind(wind), .speed(drg_speed), .speed_valid(drg_valid), .busy(drg_busy)
  );

  initial begin
    clk60MHz = 1'b0;
    forever #5 clk60MHz = ~clk60MHz;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Request a shot; checks the 1-cycle busy and 2-cycle speed latency.
  task automatic fire(input logic t, input logic cp, input int pw, input int ipw, input int w,
                      input int exp_def, input int exp_min);
    turn = t; current_player = cp; power = 4'(pw); in_power = 4'(ipw); wind = 3'(w);
    shot_start = 1'b1;
    @(negedge clk60MHz);
    shot_start = 1'b0;
    check("busy_after_start", def_busy, 1);
    check("valid_not_yet", def_valid, 0);
    @(negedge clk60MHz);
    check("speed_def", def_speed, exp_def);
    check("speed_min", min_speed, exp_min);
    check("valid_set", def_valid, 1);
    $display("shot turn=%0d cp=%0d pw=%0d ipw=%0d wind=%0d -> speed def=%0d min=%0d",
             t, cp, pw, ipw, w, def_speed, min_speed);
  endtask

  task automatic finish_shot();
    shot_done = 1'b1;
    @(negedge clk60MHz);
    shot_done = 1'b0;
    check("valid_clr_done", def_valid, 0);
    check("busy_clr_done", def_busy, 0);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk60MHz);
    frame_tick = 1'b0;
    @(negedge clk60MHz);
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; shot_start = 1'b0; shot_done = 1'b0;
    turn = 1'b0; current_player = 1'b0; power = '0; in_power = '0; wind = '0;
    repeat (2) @(negedge clk60MHz);
    check("rst_speed", def_speed, 0);
    check("rst_valid", def_valid, 0);
    check("rst_busy", def_busy, 0);
    rst = 1'b0;
    @(negedge clk60MHz);

    // P1 local, positive wind; then operand changes and a stray start must not disturb the flight
    fire(1'b0, 1'b0, 10, 0, 5, 12, 12);
    power = 4'd3; wind = 3'd0; turn = 1'b1;
    @(negedge clk60MHz);
    check("hold_after_input_change", def_speed, 12);
    shot_start = 1'b1;
    @(negedge clk60MHz);
    shot_start = 1'b0;
    @(negedge clk60MHz);
    check("fly_start_ignored_speed", def_speed, 12);
    check("fly_start_ignored_busy", def_busy, 1);
    finish_shot();
    check("speed_held_after_done", def_speed, 12);

    // P2 shooting against P1 board: remote power, wind sign flipped
    fire(1'b1, 1'b0, 0, 15, 0, 16, 16);
    finish_shot();

    // Underflow clamps to the floor
    fire(1'b0, 1'b0, 2, 0, 3, 0, 3);
    finish_shot();

    // Drag decay: one unit per two frame ticks
    fire(1'b0, 1'b0, 10, 0, 5, 12, 12);
    check("drag_start", drg_speed, 12);
    tick();
    check("drag_after_1", drg_speed, 12);
    tick();
    check("drag_after_2", drg_speed, 11);
    for (int i = 0; i < 4; i++) tick();
    check("drag_after_6", drg_speed, 9);
    check("nodrag_after_6", def_speed, 12);
    tick();
    check("drag_after_7", drg_speed, 9);
    frame_tick = 1'b1; shot_done = 1'b1;
    @(negedge clk60MHz);
    frame_tick = 1'b0; shot_done = 1'b0;
    check("drag_done_wins_speed", drg_speed, 9);
    check("drag_done_wins_valid", drg_valid, 0);

    // Start and done together in IDLE: start wins; done in CALC aborts
    power = 4'd0; wind = 3'd0; turn = 1'b0; current_player = 1'b0;
    shot_start = 1'b1; shot_done = 1'b1;
    @(negedge clk60MHz);
    shot_start = 1'b0;
    check("start_wins_busy", def_busy, 1);
    @(negedge clk60MHz);
    shot_done = 1'b0;
    check("abort_busy", def_busy, 0);
    check("abort_valid", def_valid, 0);
    check("abort_speed_def", def_speed, 12);
    check("abort_speed_drag", drg_speed, 9);
    @(negedge clk60MHz);
    check("abort_stays_idle", def_busy, 0);

    // Asynchronous reset mid-flight, observed before the next clock edge
    fire(1'b0, 1'b0, 10, 0, 5, 12, 12);
    #2 rst = 1'b1;
    #1;
    check("arst_speed", def_speed, 0);
    check("arst_valid", def_valid, 0);
    check("arst_busy", def_busy, 0);
    check("arst_drag_speed", drg_speed, 0);
    @(negedge clk60MHz);
    rst = 1'b0;
    @(negedge clk60MHz);
    check("post_rst_busy", def_busy, 0);
    check("post_rst_valid", def_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
